// File: rtl/grp_mem_writer.sv
// Group-memory writer: round-robin arbitrates four sample requesters into a
//   1024-word half of a double-buffered group memory, one write per two clocks.
// Latency: a grant registered on the ARB edge appears as oAck/oWrEn/oWrAddr/oWrData
//   in the following (WRITE) cycle. Backpressure: requesters hold iReq until oAck.
//   Once the target bank is full, further requests wait for the next bank swap.
// Ports: clk/reset (sync, active-high); iSwitch = reader bank select, where each
//   toggle is a swap; iReq/iData = four requesters with 12-bit samples;
//   oAck/oWrEn/oWrAddr/oWrData = write port; oFull, oUnderrun, oFillCnt = fill status.
module grp_mem_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        iSwitch,
  input  logic [3:0]  iReq,
  input  logic [47:0] iData,
  output logic [3:0]  oAck,
  output logic        oWrEn,
  output logic [10:0] oWrAddr,
  output logic [11:0] oWrData,
  output logic        oFull,
  output logic        oUnderrun,
  output logic [10:0] oFillCnt
);

  typedef enum logic [1:0] {IDLE, ARB, WRITE, FULL} state_t;

  localparam logic [10:0] LAST_WORD  = 11'd1023;
  localparam logic [10:0] BANK_WORDS = 11'd1024;

  state_t           state, state_nxt;
  logic             sw_prev;
  logic             bank, bank_nxt;
  logic [10:0]      ptr, ptr_nxt;
  logic [1:0]       last, last_nxt;
  logic [3:0]       ack_q, ack_nxt;
  logic             wr_en_q, wr_en_nxt;
  logic [10:0]      wr_addr_q, wr_addr_nxt;
  logic [11:0]      wr_data_q, wr_data_nxt;
  logic             full_q, full_nxt;
  logic             underrun_q, underrun_nxt;
  logic [10:0]      fill_q, fill_nxt;

  logic             swap;
  logic [3:0][11:0] samples;
  logic             rr_hit;
  logic [1:0]       rr_sel;
  logic [11:0]      sel_data;
  logic [10:0]      ptr_inc;

  assign swap    = iSwitch ^ sw_prev;
  assign samples = iData;
  assign ptr_inc = (ptr == BANK_WORDS) ? BANK_WORDS : ptr + 11'd1;

  // Round-robin search starting one past the last grant; i==4 wraps back to
  // the last winner so a lone requester is still served.
  always_comb begin : rr_pick
    rr_hit = 1'b0;
    rr_sel = last;
    for (int i = 1; i <= 4; i++) begin
      if (!rr_hit && iReq[last + 2'(i)]) begin
        rr_hit = 1'b1;
        rr_sel = last + 2'(i);
      end
    end
  end

  // Bit 11 of the first word of every 8-word phrase is reserved as a marker
  // for the reader, so sample data may never set it there.
  always_comb begin : data_pick
    sel_data = samples[rr_sel];
    if (ptr[2:0] == 3'd0) begin
      sel_data[11] = 1'b0;
    end
  end

  always_comb begin : next_state
    state_nxt    = state;
    bank_nxt     = bank;
    ptr_nxt      = ptr;
    last_nxt     = last;
    ack_nxt      = 4'b0000;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr_q;
    wr_data_nxt  = wr_data_q;
    full_nxt     = full_q;
    underrun_nxt = 1'b0;
    fill_nxt     = fill_q;

    case (state)
      IDLE: begin
        if (swap) begin
          state_nxt = ARB;
          bank_nxt  = ~iSwitch;
          ptr_nxt   = '0;
          fill_nxt  = '0;
        end
      end

      ARB: begin
        if (swap) begin
          // A swap before any word was written to this bank is not an underrun.
          bank_nxt     = ~iSwitch;
          ptr_nxt      = '0;
          fill_nxt     = '0;
          underrun_nxt = (ptr != 11'd0);
        end else if (rr_hit) begin
          state_nxt   = WRITE;
          last_nxt    = rr_sel;
          ack_nxt     = 4'b0001 << rr_sel;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = {bank, ptr[9:0]};
          wr_data_nxt = sel_data;
        end
      end

      WRITE: begin
        // The write itself is already on the output registers with the old
        // bank, so a swap here only retargets the following writes.
        ptr_nxt  = ptr_inc;
        fill_nxt = ptr_inc;
        if (swap) begin
          state_nxt    = ARB;
          bank_nxt     = ~iSwitch;
          ptr_nxt      = '0;
          fill_nxt     = '0;
          underrun_nxt = (ptr != LAST_WORD);
        end else if (ptr == LAST_WORD) begin
          state_nxt = FULL;
          full_nxt  = 1'b1;
        end else begin
          state_nxt = ARB;
        end
      end

      FULL: begin
        if (swap) begin
          state_nxt = ARB;
          bank_nxt  = ~iSwitch;
          ptr_nxt   = '0;
          fill_nxt  = '0;
          full_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin : data_reg
    // Track iSwitch even in reset so that leaving reset never looks like a swap.
    sw_prev <= iSwitch;
    if (reset) begin
      bank       <= 1'b0;
      ptr        <= '0;
      last       <= 2'd3;
      ack_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
      fill_q     <= '0;
    end else begin
      bank       <= bank_nxt;
      ptr        <= ptr_nxt;
      last       <= last_nxt;
      ack_q      <= ack_nxt;
      wr_en_q    <= wr_en_nxt;
      wr_addr_q  <= wr_addr_nxt;
      wr_data_q  <= wr_data_nxt;
      full_q     <= full_nxt;
      underrun_q <= underrun_nxt;
      fill_q     <= fill_nxt;
    end
  end

  // Strobe and ack are registered, but reset also masks them within the
  // cycle so that a reset landing in a WRITE cycle aborts that write.
  assign oAck      = ack_q & {4{~reset}};
  assign oWrEn     = wr_en_q & ~reset;
  assign oWrAddr   = wr_addr_q;
  assign oWrData   = wr_data_q;
  assign oFull     = full_q;
  assign oUnderrun = underrun_q;
  assign oFillCnt  = fill_q;

endmodule

// File: tb/tb_grp_mem_writer.sv
// Directed bench for grp_mem_writer: requesters drop iReq after an ack and
//   re-raise it one edge later; a monitor logs every write at the falling edge.
module tb_grp_mem_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iSwitch = 1'b0;
  logic [3:0]  iReq = 4'b0000;
  logic [47:0] iData = '0;
  logic [3:0]  oAck;
  logic        oWrEn;
  logic [10:0] oWrAddr;
  logic [11:0] oWrData;
  logic        oFull;
  logic        oUnderrun;
  logic [10:0] oFillCnt;

  always #5 clk = ~clk;

  grp_mem_writer dut (
    .clk(clk), .reset(reset), .iSwitch(iSwitch), .iReq(iReq), .iData(iData),
    .oAck(oAck), .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oFull(oFull), .oUnderrun(oUnderrun), .oFillCnt(oFillCnt)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester model
  logic [3:0] auto_req = 4'b0000;
  logic [3:0] ack_seen = 4'b0000;
  always @(negedge clk) ack_seen = oAck;
  always @(posedge clk) begin
    #1;
    iReq = auto_req & ~ack_seen;
  end

  // Write monitor
  int cyc = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;
  int und_cnt = 0;
  logic [10:0] wa_q[$];
  logic [11:0] wd_q[$];
  logic [3:0]  wk_q[$];
  int          wc_q[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (oWrEn) begin
      wa_q.push_back(oWrAddr);
      wd_q.push_back(oWrData);
      wk_q.push_back(oAck);
      wc_q.push_back(cyc);
      wr_cnt++;
    end
    if (oAck != 4'b0000) ack_cnt++;
    if (oUnderrun) und_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wr_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("wait_writes", 48'(wr_cnt >= n), 48'd1);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, base2, base3, c, a, u;
    int k;

    // Reset values
    do_reset();
    at_neg();
    chk("rst_ack",   oAck,      4'h0);
    chk("rst_wren",  oWrEn,     1'b0);
    chk("rst_addr",  oWrAddr,   11'h000);
    chk("rst_data",  oWrData,   12'h000);
    chk("rst_full",  oFull,     1'b0);
    chk("rst_under", oUnderrun, 1'b0);
    chk("rst_fill",  oFillCnt,  11'd0);

    // IDLE ignores requests until the first swap
    iData = {12'h000, 12'h000, 12'h000, 12'hFFF};
    auto_req = 4'b0001;
    tick(5);
    chk("idle_no_write", wr_cnt, 0);

    // First writes after swap 0->1: bank 0, marker bit cleared on word 0
    iSwitch = 1'b1;
    wait_writes(2, 50);
    auto_req = 4'b0000;
    chk("w0_addr", wa_q[0], 11'h000);
    chk("w0_data", wd_q[0], 12'h7FF);
    chk("w0_ack",  wk_q[0], 4'b0001);
    chk("w1_addr", wa_q[1], 11'h001);
    chk("w1_data", wd_q[1], 12'hFFF);
    tick(3);
    at_neg();
    chk("fill_2", oFillCnt, 11'd2);

    // Swap while waiting in ARB with 2 words written -> one underrun pulse
    tick(1);
    iSwitch = 1'b0;
    tick(4);
    chk("arb_underrun_cnt", und_cnt, 1);
    at_neg();
    chk("arb_swap_fill", oFillCnt, 11'd0);

    // Four requesters held high: grants 0,1,2,3,... every 2 clocks
    do_reset();
    iData = {12'hA33, 12'hA22, 12'hA11, 12'hA00};
    auto_req = 4'b1111;
    base = wr_cnt;
    iSwitch = 1'b1;
    wait_writes(base + 8, 100);
    auto_req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      logic [11:0] ed;
      ed = (i == 0) ? 12'h200 : (12'hA00 | 12'(12'h11 * (i % 4)));
      chk($sformatf("rr_ack%0d", i),  wk_q[base+i], 4'b0001 << (i % 4));
      chk($sformatf("rr_addr%0d", i), wa_q[base+i], 11'(i));
      chk($sformatf("rr_data%0d", i), wd_q[base+i], ed);
      if (i > 0) chk($sformatf("rr_gap%0d", i), wc_q[base+i] - wc_q[base+i-1], 2);
    end
    tick(4);

    // Swap after 500 writes -> underrun, then fill 1024 words -> full
    do_reset();
    auto_req = 4'b1111;
    base = wr_cnt;
    iSwitch = 1'b0;                      // bank 1
    wait_writes(base + 500, 1200);
    iSwitch = 1'b1;
    u = und_cnt;
    at_neg();
    chk("fill_500", oFillCnt, 11'd500);
    chk("w499_addr", wa_q[base+499], {1'b1, 10'd499});
    tick(1);
    at_neg();
    chk("under_pulse", oUnderrun, 1'b1);
    chk("under_fill0", oFillCnt, 11'd0);
    wait_writes(base + 501, 20);
    chk("after_under_addr", wa_q[base+500], 11'h000);
    tick(4);
    chk("under_once", und_cnt - u, 1);

    base2 = base + 500;
    wait_writes(base2 + 1024, 2300);
    at_neg();
    chk("full_flag", oFull, 1'b1);
    chk("full_fill", oFillCnt, 11'd1024);
    chk("w1023_addr", wa_q[base2+1023], 11'h3FF);
    c = wr_cnt;
    a = ack_cnt;
    tick(20);
    chk("full_no_write", wr_cnt, c);
    chk("full_no_ack", ack_cnt, a);
    u = und_cnt;
    iSwitch = 1'b0;
    tick(2);
    at_neg();
    chk("full_cleared", oFull, 1'b0);
    wait_writes(c + 1, 20);
    chk("after_full_addr", wa_q[c], 11'h400);
    chk("full_swap_no_under", und_cnt, u);
    auto_req = 4'b0000;
    tick(4);

    // Swap coincident with the write of word 1023
    do_reset();
    auto_req = 4'b1111;
    base3 = wr_cnt;
    iSwitch = 1'b1;                      // bank 0
    wait_writes(base3 + 1023, 2300);
    tick(1);                             // word 1023 granted on this edge
    iSwitch = 1'b0;
    u = und_cnt;
    wait_writes(base3 + 1025, 20);
    chk("last_word_addr", wa_q[base3+1023], 11'h3FF);
    chk("new_bank_addr",  wa_q[base3+1024], 11'h400);
    chk("last_word_no_under", und_cnt, u);
    at_neg();
    chk("last_word_no_full", oFull, 1'b0);
    chk("new_bank_fill", oFillCnt, 11'd1);

    // Reset during a WRITE cycle
    k = 0;
    do begin
      at_neg();
      k++;
    end while (!oWrEn && k < 10);
    chk("found_write", oWrEn, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_wren", oWrEn, 1'b0);
    chk("rst_mid_ack",  oAck,  4'h0);
    tick(2);
    reset = 1'b0;
    at_neg();
    chk("rst_mid_addr",  oWrAddr,   11'h000);
    chk("rst_mid_data",  oWrData,   12'h000);
    chk("rst_mid_full",  oFull,     1'b0);
    chk("rst_mid_under", oUnderrun, 1'b0);
    chk("rst_mid_fill",  oFillCnt,  11'd0);
    c = wr_cnt;
    tick(10);
    chk("rst_mid_idle", wr_cnt, c);
    auto_req = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/grp_mem_writer.md
GRP_MEM_WRITER -- requirements
Module: grp_mem_writer

Interface
REQ-001 Clocking: the block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  system clock, 12'582'912 Hz, all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: iSwitch  input  1  bank-select from the frame reader; the reader reads bank iSwitch, and every level change is a bank swap.
REQ-005 Port: iReq  input  4  per-requester write request; the requester holds it high until acknowledged.
REQ-006 Port: iData  input  48  four 12-bit samples, requester n on bits [12n+11:12n], held stable while iReq[n] is high.
REQ-007 Port: oAck  output  4  one-hot, one-cycle grant/acknowledge.
REQ-008 Port: oWrEn  output  1  group-memory write strobe.
REQ-009 Port: oWrAddr  output  11  {bank, word[9:0]} write address.
REQ-010 Port: oWrData  output  12  write data.
REQ-011 Port: oFull  output  1  the target bank holds 1024 words.
REQ-012 Port: oUnderrun  output  1  one-cycle pulse when a swap occurs before the bank is full.
REQ-013 Port: oFillCnt  output  11  number of words written to the current bank, 0..1024.

Function
REQ-014 Swap detect: the block SHALL register iSwitch into swPrev; swap = iSwitch XOR swPrev, and swPrev SHALL be set to iSwitch at reset so that reset itself creates no swap.
REQ-015 States: the block SHALL implement IDLE, ARB, WRITE and FULL.
REQ-016 IDLE: the block SHALL issue no acks and no writes, and on swap SHALL go to ARB with bank=~iSwitch and ptr=0.
REQ-017 ARB, no swap: if any iReq bit is high, the block SHALL latch grant g by round-robin starting at last+1 (mod 4), latch data=iData[g], set last=g, and go to WRITE; if no iReq bit is high, it SHALL stay in ARB.
REQ-018 WRITE cycle outputs: in the WRITE cycle, oAck[g]=1 and oWrEn=1, with oWrAddr={bank,ptr[9:0]} and oWrData=data; all other cycles have oAck=0 and oWrEn=0.
REQ-019 Marker reservation: when ptr[2:0]==0 (word 0 of each 8-word phrase), oWrData[11] SHALL be forced to 0.
REQ-020 WRITE end: ptr SHALL increment, with oFillCnt=ptr; if ptr was 1023, the block SHALL go to FULL with oFull=1, otherwise it SHALL return to ARB.
REQ-021 Throughput: the block SHALL sustain at most one write per 2 clocks, and the requester SHALL drop iReq on the edge after it sees oAck, so the following ARB cycle never re-grants a stale request.
REQ-022 FULL: the block SHALL issue no acks and no writes; on swap it SHALL go to ARB with bank=~iSwitch, ptr=0 and oFull=0, and oUnderrun SHALL stay 0.
REQ-023 Swap in ARB: ptr SHALL go to 0 and bank to ~iSwitch; oUnderrun=1 for one cycle if ptr!=0 at the swap, otherwise 0; no grant SHALL be made in that cycle.
REQ-024 Swap in WRITE: the write SHALL still complete to the old latched bank, and the next state SHALL be ARB with ptr=0 and the new bank.
REQ-025 Swap in WRITE, underrun: oUnderrun SHALL pulse unless that write was word 1023, in which case the fill counts as complete and there is no pulse.
REQ-026 Width rules: ptr and oFillCnt SHALL be 11-bit and saturate at 1024; oWrAddr SHALL use ptr[9:0] only.
REQ-027 Registered outputs: all outputs SHALL be registered, with no combinational path from iReq or iData to any output.

Reset
REQ-028 Reset outputs: on reset the block SHALL set state=IDLE and oAck=0, oWrEn=0, oWrAddr=0, oWrData=0, oFull=0, oUnderrun=0 and oFillCnt=0.
REQ-029 Reset internals: on reset the block SHALL set ptr=0, bank=0, last=3 (so requester 0 wins first) and swPrev=iSwitch.
REQ-030 Reset mid-operation: reset during WRITE SHALL suppress that cycle's oWrEn and oAck (reset wins), and any pending request SHALL wait for the next swap.

Verification
REQ-031 Scenario: reset, iSwitch 0->1, iReq=4'b0001, iData[11:0]=12'hFFF -> first write is oWrAddr=11'h000, oWrData=12'h7FF (marker bit cleared), oAck=4'b0001, and the next write to addr 1 carries 12'hFFF.
REQ-032 Scenario: all four requesters held high continuously -> grants 0,1,2,3,0... with one oWrEn every 2 clocks and addresses incrementing by 1.
REQ-033 Scenario: 1024 writes after a swap -> oFull=1 and oFillCnt=1024, further iReq gets no oAck, and the next swap clears oFull with oUnderrun=0.
REQ-034 Scenario: swap after 500 writes -> oUnderrun pulses 1 cycle, the next write goes to {~iSwitch,10'h000}, and oFillCnt=0 before that write.
REQ-035 Scenario: swap coincident with the WRITE of word 1023 -> the write lands in the old bank, there is no oUnderrun, and the next write goes to word 0 of the new bank.
REQ-036 Scenario: reset asserted during a WRITE cycle -> oWrEn=0 and oAck=0 in that cycle, all outputs go to reset values, and state=IDLE.
